// File: rtl/step_positioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : step_positioner                                        |
// | Description : Issues a programmed number of step strobes at a fixed  |
// |               clock period, tracks a half-step position counter and  |
// |               reports busy/done status to the host.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module step_positioner #(
  parameter int STEP_W = 12,
  parameter int DIV_W  = 16,
  parameter int POS_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [STEP_W-1:0] STEPS,
  input  logic              DIR,
  input  logic              MODE,
  input  logic [DIV_W-1:0]  RATE,
  input  logic              ABORT,
  input  logic              POS_CLR,
  output logic              ENABLE,
  output logic              HALF_FULL,
  output logic              UP_DOWN,
  output logic              BUSY,
  output logic              DONE,
  output logic [POS_W-1:0]  POS
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_RUN    = 2'd1;
  localparam logic [1:0] C_FINISH = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [STEP_W-1:0] rem_q,       rem_d;
  logic [DIV_W-1:0]  rate_q,      rate_d;
  logic [DIV_W-1:0]  cnt_q,       cnt_d;
  logic              enable_q,    enable_d;
  logic              half_full_q, half_full_d;
  logic              up_down_q,   up_down_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic [POS_W-1:0]  pos_q,       pos_d;

  logic              w_tc;
  logic [POS_W-1:0]  w_pos_inc;

  // Latched rate is never 0, so rate_q - 1 is always a valid terminal count.
  assign w_tc      = (cnt_q == (rate_q - DIV_W'(1)));
  assign w_pos_inc = half_full_q ? POS_W'(1) : POS_W'(2);

  // State register with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a RUN move finishes once the last strobe has been seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE: begin
        if (START) begin
          state_d = (STEPS == '0) ? C_FINISH : C_RUN;
        end
      end
      C_RUN: begin
        if (ABORT || (rem_q == '0)) begin
          state_d = C_FINISH;
        end
      end
      C_FINISH: state_d = C_IDLE;
      default:  state_d = C_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    rem_d       = rem_q;
    rate_d      = rate_q;
    cnt_d       = cnt_q;
    enable_d    = 1'b0;
    half_full_d = half_full_q;
    up_down_d   = up_down_q;
    pos_d       = pos_q;

    if ((state_q == C_IDLE) && START && (STEPS != '0)) begin
      rem_d       = STEPS;
      rate_d      = (RATE == '0) ? DIV_W'(1) : RATE;
      half_full_d = MODE;
      up_down_d   = DIR;
      cnt_d       = '0;
    end

    // ABORT suppresses the strobe and its position update in the same cycle.
    if ((state_q == C_RUN) && !ABORT && (rem_q != '0)) begin
      if (w_tc) begin
        cnt_d    = '0;
        enable_d = 1'b1;
        rem_d    = rem_q - STEP_W'(1);
        pos_d    = up_down_q ? (pos_q + w_pos_inc) : (pos_q - w_pos_inc);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // Position clear only outside a move; applies alongside a new START.
    if (POS_CLR && !busy_q) begin
      pos_d = '0;
    end

    busy_d = (state_d == C_RUN);
    done_d = (state_d == C_FINISH);
  end

  // Datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rem_q       <= '0;
      rate_q      <= '0;
      cnt_q       <= '0;
      enable_q    <= 1'b0;
      half_full_q <= 1'b0;
      up_down_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pos_q       <= '0;
    end else begin
      rem_q       <= rem_d;
      rate_q      <= rate_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      half_full_q <= half_full_d;
      up_down_q   <= up_down_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pos_q       <= pos_d;
    end
  end

  assign ENABLE    = enable_q;
  assign HALF_FULL = half_full_q;
  assign UP_DOWN   = up_down_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign POS       = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_step_positioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_step_positioner                                     |
// | Description : Directed self-checking bench for step_positioner.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_step_positioner;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [11:0] STEPS;
  logic        DIR;
  logic        MODE;
  logic [15:0] RATE;
  logic        ABORT;
  logic        POS_CLR;
  logic        ENABLE;
  logic        HALF_FULL;
  logic        UP_DOWN;
  logic        BUSY;
  logic        DONE;
  logic [15:0] POS;

  int n_cmp = 0;
  int n_err = 0;
  int n_en  = 0;

  step_positioner dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .STEPS     (STEPS),
    .DIR       (DIR),
    .MODE      (MODE),
    .RATE      (RATE),
    .ABORT     (ABORT),
    .POS_CLR   (POS_CLR),
    .ENABLE    (ENABLE),
    .HALF_FULL (HALF_FULL),
    .UP_DOWN   (UP_DOWN),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .POS       (POS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a move request for exactly one rising edge.
  task automatic start_move(input logic [11:0] s, input logic [15:0] r, input logic d, input logic m);
    STEPS = s;
    RATE  = r;
    DIR   = d;
    MODE  = m;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int k;
    k = 0;
    while (!DONE && k < bound) begin
      tick();
      k++;
    end
    chk(tag, DONE, 1'b1);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET = 1'b0; START = 1'b0; STEPS = '0; DIR = 1'b0; MODE = 1'b0;
    RATE = '0; ABORT = 1'b0; POS_CLR = 1'b0;
    tick(); tick();
    chk("rst_enable", ENABLE, 1'b0);
    chk("rst_half",   HALF_FULL, 1'b0);
    chk("rst_updown", UP_DOWN, 1'b0);
    chk("rst_busy",   BUSY, 1'b0);
    chk("rst_done",   DONE, 1'b0);
    chk("rst_pos",    POS, 16'h0000);
    RESET = 1'b1;
    tick();

    // 4 half-steps up, period 3
    start_move(12'd4, 16'd3, 1'b1, 1'b1);
    chk("t1_busy0", BUSY, 1'b1);
    chk("t1_en0",   ENABLE, 1'b0);
    chk("t1_ud0",   UP_DOWN, 1'b1);
    chk("t1_hf0",   HALF_FULL, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("t1_en_k%0d", k),   ENABLE, (k % 3 == 0) && (k <= 12));
      chk($sformatf("t1_done_k%0d", k), DONE,   k == 13);
      chk($sformatf("t1_busy_k%0d", k), BUSY,   k <= 12);
      if (k == 6)  chk("t1_pos_mid", POS, 16'd2);
      if (k == 12) chk("t1_pos_end", POS, 16'd4);
    end
    chk("t1_hold_ud", UP_DOWN, 1'b1);
    chk("t1_hold_hf", HALF_FULL, 1'b1);

    // POS_CLR in IDLE, then 3 full-steps down, period 2
    POS_CLR = 1'b1; tick(); POS_CLR = 1'b0;
    chk("t2_clr", POS, 16'h0000);
    start_move(12'd3, 16'd2, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t2_en_k%0d", k),   ENABLE, (k % 2 == 0) && (k <= 6));
      chk($sformatf("t2_done_k%0d", k), DONE,   k == 7);
      chk($sformatf("t2_ud_k%0d", k),   UP_DOWN, 1'b0);
      chk($sformatf("t2_hf_k%0d", k),   HALF_FULL, 1'b0);
    end
    chk("t2_pos", POS, 16'hFFFA);

    // Zero-length move
    start_move(12'd0, 16'd5, 1'b1, 1'b1);
    chk("t3_done",  DONE, 1'b1);
    chk("t3_busy",  BUSY, 1'b0);
    chk("t3_en",    ENABLE, 1'b0);
    chk("t3_ud",    UP_DOWN, 1'b0);
    tick();
    chk("t3_done_off", DONE, 1'b0);
    chk("t3_pos",      POS, 16'hFFFA);

    // RATE=0 behaves as 1: strobes on consecutive clocks
    start_move(12'd2, 16'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t3r_en_k%0d", k),   ENABLE, k <= 2);
      chk($sformatf("t3r_done_k%0d", k), DONE,   k == 3);
    end
    chk("t3r_pos", POS, 16'hFFFC);

    // Abort on the terminal-count cycle of the second step
    POS_CLR = 1'b1; tick(); POS_CLR = 1'b0;
    n_en = 0;
    start_move(12'd5, 16'd2, 1'b1, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (ENABLE) n_en++;
    end
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    if (ENABLE) n_en++;
    chk("t4_en_abort", ENABLE, 1'b0);
    chk("t4_done",     DONE, 1'b1);
    chk("t4_busy",     BUSY, 1'b0);
    chk("t4_pos",      POS, 16'd1);
    tick();
    if (ENABLE) n_en++;
    chk("t4_done_off", DONE, 1'b0);
    chk("t4_en_count", n_en, 1);

    // Climb to 0x7FF8 with full-steps at rate 1
    POS_CLR = 1'b1; tick(); POS_CLR = 1'b0;
    for (int m = 0; m < 4; m++) begin
      start_move(12'd4095, 16'd1, 1'b1, 1'b0);
      wait_done($sformatf("t5_climb_done%0d", m), 5000);
    end
    chk("t5_climb_pos", POS, 16'h7FF8);

    // START and POS_CLR during RUN are ignored
    start_move(12'd3, 16'd2, 1'b1, 1'b0);
    tick();
    START = 1'b1; STEPS = 12'd7; DIR = 1'b0; MODE = 1'b1; POS_CLR = 1'b1;
    tick();
    START = 1'b0; POS_CLR = 1'b0;
    chk("t5_run_en",  ENABLE, 1'b1);
    chk("t5_run_pos", POS, 16'h7FFA);
    chk("t5_run_ud",  UP_DOWN, 1'b1);
    chk("t5_run_hf",  HALF_FULL, 1'b0);
    for (int k = 3; k <= 8; k++) begin
      tick();
      chk($sformatf("t5_en_k%0d", k),   ENABLE, (k == 4) || (k == 6));
      chk($sformatf("t5_done_k%0d", k), DONE,   k == 7);
      chk($sformatf("t5_busy_k%0d", k), BUSY,   k <= 6);
    end
    chk("t5_pos_7ffe", POS, 16'h7FFE);

    // Half-steps across the sign boundary
    start_move(12'd1, 16'd1, 1'b1, 1'b1);
    wait_done("t5_h1_done", 10);
    chk("t5_pos_7fff", POS, 16'h7FFF);
    start_move(12'd1, 16'd1, 1'b1, 1'b1);
    wait_done("t5_h2_done", 10);
    chk("t5_pos_8000", POS, 16'h8000);

    // Reset mid-move: immediate clear, no DONE
    start_move(12'd10, 16'd2, 1'b1, 1'b1);
    tick(); tick(); tick();
    chk("t6_pre_pos", POS, 16'h8001);
    #3;
    RESET = 1'b0;
    #1;
    chk("t6_enable", ENABLE, 1'b0);
    chk("t6_half",   HALF_FULL, 1'b0);
    chk("t6_updown", UP_DOWN, 1'b0);
    chk("t6_busy",   BUSY, 1'b0);
    chk("t6_done",   DONE, 1'b0);
    chk("t6_pos",    POS, 16'h0000);
    tick();
    chk("t6_done_hold", DONE, 1'b0);

    // START accepted on the first edge after reset release
    RESET = 1'b1;
    start_move(12'd1, 16'd1, 1'b1, 1'b0);
    chk("t7_busy", BUSY, 1'b1);
    chk("t7_done_pre", DONE, 1'b0);
    tick();
    chk("t7_en",  ENABLE, 1'b1);
    chk("t7_pos", POS, 16'd2);
    tick();
    chk("t7_done", DONE, 1'b1);
    chk("t7_en_off", ENABLE, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
